// File: rtl/controlador_vga.sv
// VGA timing generator: pixel-rate divider plus horizontal/vertical phase FSMs.
// Every output is a registered decode of the count value presented with it.
module controlador_vga #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FRONT  = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BACK   = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FRONT  = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BACK   = 33,
  parameter int unsigned CLK_DIV  = 2,
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned W        = 10
) (
  input  logic         reloj,
  input  logic         reset,
  input  logic         habilitar,
  output logic         pixel_tick,
  output logic [W-1:0] pixel_x,
  output logic [W-1:0] pixel_y,
  output logic         hsync,
  output logic         vsync,
  output logic         video_activo,
  output logic         inicio_cuadro,
  output logic         fin_linea
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [W-1:0] H_LAST = W'(H_TOTAL - 1);
  localparam logic [W-1:0] H_FP   = W'(H_ACTIVE);
  localparam logic [W-1:0] H_SY   = W'(H_ACTIVE + H_FRONT);
  localparam logic [W-1:0] H_BP   = W'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [W-1:0] V_LAST = W'(V_TOTAL - 1);
  localparam logic [W-1:0] V_FP   = W'(V_ACTIVE);
  localparam logic [W-1:0] V_SY   = W'(V_ACTIVE + V_FRONT);
  localparam logic [W-1:0] V_BP   = W'(V_ACTIVE + V_FRONT + V_SYNC);

  typedef enum logic [1:0] {H_VISIBLE, H_FRONT_P, H_SYNCRO, H_BACK_P} h_state_e;
  typedef enum logic [1:0] {V_VISIBLE, V_FRONT_P, V_SYNCRO, V_BACK_P} v_state_e;

  logic [DIV_W-1:0] div_q, div_d;
  logic [W-1:0]     x_q, x_d, y_q, y_d;
  h_state_e         h_q, h_d;
  v_state_e         v_q, v_d;
  logic             tick_q, tick_d;
  logic             hs_q, hs_d, vs_q, vs_d, va_q, va_d;
  logic             ini_q, ini_d, fin_q, fin_d;
  logic             adv, x_wrap, y_wrap;

  // Next-state: counters and phases move only on a divider wrap.
  always_comb begin
    adv    = (div_q == DIV_LAST);
    x_wrap = 1'b0;
    y_wrap = 1'b0;
    div_d  = adv ? '0 : div_q + DIV_W'(1);
    tick_d = adv;
    x_d    = x_q;
    y_d    = y_q;
    h_d    = h_q;
    v_d    = v_q;
    ini_d  = 1'b0;
    fin_d  = 1'b0;

    if (adv) begin
      x_wrap = (x_q == H_LAST);
      y_wrap = (y_q == V_LAST);
      x_d    = x_wrap ? '0 : x_q + W'(1);
      if (x_wrap) begin
        y_d   = y_wrap ? '0 : y_q + W'(1);
        fin_d = 1'b1;
        ini_d = y_wrap;
      end

      case (h_q)
        H_VISIBLE: if (x_d == H_FP) h_d = H_FRONT_P;
        H_FRONT_P: if (x_d == H_SY) h_d = H_SYNCRO;
        H_SYNCRO:  if (x_d == H_BP) h_d = H_BACK_P;
        H_BACK_P:  if (x_wrap)      h_d = H_VISIBLE;
        default:   h_d = H_VISIBLE;
      endcase

      if (x_wrap) begin
        case (v_q)
          V_VISIBLE: if (y_d == V_FP) v_d = V_FRONT_P;
          V_FRONT_P: if (y_d == V_SY) v_d = V_SYNCRO;
          V_SYNCRO:  if (y_d == V_BP) v_d = V_BACK_P;
          V_BACK_P:  if (y_wrap)      v_d = V_VISIBLE;
          default:   v_d = V_VISIBLE;
        endcase
      end
    end

    // Disable behaves exactly like reset, one clock later.
    if (!habilitar) begin
      div_d  = '0;
      tick_d = 1'b0;
      x_d    = '0;
      y_d    = '0;
      h_d    = H_VISIBLE;
      v_d    = V_VISIBLE;
      ini_d  = 1'b0;
      fin_d  = 1'b0;
    end

    hs_d = (h_d == H_SYNCRO) ? SYNC_POL : ~SYNC_POL;
    vs_d = (v_d == V_SYNCRO) ? SYNC_POL : ~SYNC_POL;
    va_d = (h_d == H_VISIBLE) && (v_d == V_VISIBLE);
  end

  always_ff @(posedge reloj or negedge reset) begin
    if (!reset) begin
      div_q  <= '0;
      tick_q <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      h_q    <= H_VISIBLE;
      v_q    <= V_VISIBLE;
      hs_q   <= ~SYNC_POL;
      vs_q   <= ~SYNC_POL;
      va_q   <= 1'b1;
      ini_q  <= 1'b0;
      fin_q  <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
      x_q    <= x_d;
      y_q    <= y_d;
      h_q    <= h_d;
      v_q    <= v_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      va_q   <= va_d;
      ini_q  <= ini_d;
      fin_q  <= fin_d;
    end
  end

  assign pixel_tick    = tick_q;
  assign pixel_x       = x_q;
  assign pixel_y       = y_q;
  assign hsync         = hs_q;
  assign vsync         = vs_q;
  assign video_activo  = va_q;
  assign inicio_cuadro = ini_q;
  assign fin_linea     = fin_q;

endmodule

// File: tb/tb_controlador_vga.sv
// Bench for controlador_vga: a default-timing instance for line/enable/reset
// behaviour and a tiny-timing instance for full-frame vsync and frame pulses.
module tb_controlador_vga;

  logic clk;
  logic rst_a, en_a, rst_b, en_b;

  logic       a_tick, a_hs, a_vs, a_va, a_ini, a_fin;
  logic [9:0] a_x, a_y;
  logic       b_tick, b_hs, b_vs, b_va, b_ini, b_fin;
  logic [9:0] b_x, b_y;

  int n_checks = 0;
  int n_fail   = 0;

  controlador_vga dut_a (
    .reloj(clk), .reset(rst_a), .habilitar(en_a),
    .pixel_tick(a_tick), .pixel_x(a_x), .pixel_y(a_y),
    .hsync(a_hs), .vsync(a_vs), .video_activo(a_va),
    .inicio_cuadro(a_ini), .fin_linea(a_fin)
  );

  controlador_vga #(
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
    .V_ACTIVE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .CLK_DIV(1), .SYNC_POL(1'b1), .W(10)
  ) dut_b (
    .reloj(clk), .reset(rst_b), .habilitar(en_b),
    .pixel_tick(b_tick), .pixel_x(b_x), .pixel_y(b_y),
    .hsync(b_hs), .vsync(b_vs), .video_activo(b_va),
    .inicio_cuadro(b_ini), .fin_linea(b_fin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         steps;
    logic [9:0] x;
    logic [9:0] y;
    logic       tick, hs, vs, va, ini, fin;
  } vec_t;

  // Expected outputs after k enabled clocks: {tick,hs,vs,va,ini,fin,x,y}
  function automatic logic [25:0] model(input int k, input int dv, input int ht, input int ha,
                                        input int hs0, input int hs1, input int vt, input int vact,
                                        input int vs0, input int vs1, input bit pol);
    int p, x, y;
    logic t, hs, vs, va;
    p  = k / dv;
    x  = p % ht;
    y  = (p / ht) % vt;
    t  = (k > 0) && (k % dv == 0);
    hs = (x >= hs0 && x <= hs1) ? pol : !pol;
    vs = (y >= vs0 && y <= vs1) ? pol : !pol;
    va = (x < ha) && (y < vact);
    return {t, hs, vs, va, t && x == 0 && y == 0, t && x == 0, 10'(x), 10'(y)};
  endfunction

  function automatic logic [25:0] model_a(input int k);
    return model(k, 2, 800, 640, 656, 751, 525, 480, 490, 491, 1'b0);
  endfunction

  function automatic logic [25:0] model_b(input int k);
    return model(k, 1, 7, 4, 5, 5, 5, 2, 3, 3, 1'b1);
  endfunction

  function automatic logic [25:0] act_a();
    return {a_tick, a_hs, a_vs, a_va, a_ini, a_fin, a_x, a_y};
  endfunction

  function automatic logic [25:0] act_b();
    return {b_tick, b_hs, b_vs, b_va, b_ini, b_fin, b_x, b_y};
  endfunction

  task automatic cmp(input string name, input int k, input logic [25:0] act, input logic [25:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s k=%0d: got tick/hs/vs/va/ini/fin=%b x=%0d y=%0d, expected %b x=%0d y=%0d",
               name, k, act[25:20], act[19:10], act[9:0], exp[25:20], exp[19:10], exp[9:0]);
    end
  endtask

  vec_t tbl[13];
  int   kb;

  initial begin
    tbl[0]  = '{0,  10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1,  10'd1, 10'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{3,  10'd4, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1,  10'd5, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1,  10'd6, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1,  10'd0, 10'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{1,  10'd1, 10'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{6,  10'd0, 10'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{7,  10'd0, 10'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{5,  10'd5, 10'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{2,  10'd0, 10'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{7,  10'd0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[12] = '{1,  10'd1, 10'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    rst_a = 1'b0; en_a = 1'b1;
    rst_b = 1'b0; en_b = 1'b1;

    // Default timing: reset state, then two lines plus 300 pixels clock by clock.
    @(negedge clk);
    cmp("a_reset", 0, act_a(), model_a(0));
    rst_a = 1'b1;
    for (int k = 1; k <= 3800; k++) begin
      @(negedge clk);
      cmp("a_run", k, act_a(), model_a(k));
    end

    // Enable drop at (300,2): reset values from the next clock on.
    en_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cmp("a_disabled", 0, act_a(), model_a(0));
    end
    en_a = 1'b1;
    for (int k = 1; k <= 1400; k++) begin
      @(negedge clk);
      cmp("a_restart", k, act_a(), model_a(k));
    end

    // Inside the hsync pulse (x=700): async reset acts between edges.
    #2 rst_a = 1'b0;
    #1 cmp("a_async_reset", 0, act_a(), model_a(0));
    @(negedge clk);
    cmp("a_reset_hold", 0, act_a(), model_a(0));

    // Tiny timing: table of hand-computed points, then a full-frame sweep.
    rst_b = 1'b1;
    kb = 0;
    foreach (tbl[i]) begin
      repeat (tbl[i].steps) @(negedge clk);
      kb += tbl[i].steps;
      cmp("b_table", kb, act_b(),
          {tbl[i].tick, tbl[i].hs, tbl[i].vs, tbl[i].va, tbl[i].ini, tbl[i].fin, tbl[i].x, tbl[i].y});
    end
    for (int k = kb + 1; k <= kb + 35; k++) begin
      @(negedge clk);
      cmp("b_frame", k, act_b(), model_b(k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
